pc_sequencer: RTL and testbench
===============================

# pc_sequencer

Program-counter sequencer directly downstream of the jump-target mini ALU. Holds the fetch PC, steps it each cycle, and on a jump request loads the 32-bit target produced by the mini ALU through a request/acknowledge handshake. After each taken jump it drives a fixed-length pipeline flush, and it traps misaligned targets in a sticky fault state.

## Interface
Parameters:
- RESET_PC, 32'h0000_0000, PC value after reset.
- PC_STEP, 4, sequential increment added each unstalled RUN cycle.
- FLUSH_CYCLES, 2, flush length after a taken jump; legal range 1..15.

Ports:
- clk  in  1  single clock; all state changes on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- STALL  in  1  holds PC in RUN; does not extend an active flush.
- JMP_REQ  in  1  jump request; requester holds it high until JMP_ACK.
- JMP_TARGET  in  32  jump target; connected to the mini ALU output.
- PC  out  32  current fetch address (registered).
- PC_VALID  out  1  PC is a valid fetch address.
- JMP_ACK  out  1  one-cycle pulse: the jump was accepted.
- RET_ADDR  out  32  link address, PC+PC_STEP captured at jump acceptance.
- FLUSH  out  1  high for the whole flush window.
- MISALIGN  out  1  sticky misaligned-target fault.

## Operation
- States: RUN, FLUSH, FAULT. Flush counter is 4 bits.
- RUN, JMP_REQ=1, STALL=0, JMP_TARGET[1:0]=0 (accept):
  - PC <= JMP_TARGET; RET_ADDR <= PC+PC_STEP (old PC).
  - JMP_ACK <= 1; counter <= FLUSH_CYCLES-1; state <= FLUSH.
- RUN, JMP_REQ=1, STALL=0, JMP_TARGET[1:0]!=0: state <= FAULT; MISALIGN <= 1; PC held; no JMP_ACK.
- RUN, JMP_REQ=0, STALL=0: PC <= PC+PC_STEP, modulo 2^32. 32'hFFFF_FFFC+4 wraps to 0 with no flag.
- RUN, STALL=1: PC held. JMP_REQ waits, not lost, and is acted on in the first cycle with STALL=0.
- FLUSH:
  - PC held; JMP_REQ ignored (no ack); STALL ignored.
  - Counter decrements each cycle; at count 0, state <= RUN.
- FAULT: PC, RET_ADDR and MISALIGN held. All inputs ignored. Exit only by reset.
- Output decode (Moore):
  - PC_VALID = (state==RUN).
  - FLUSH = (state==FLUSH).
  - JMP_ACK is a register, cleared every cycle it is not set.

## Timing
- Reset, asynchronous on rst_n=0:
  - PC=RESET_PC, RET_ADDR=0, state=RUN, counter=0.
  - JMP_ACK=0, MISALIGN=0, FLUSH=0, PC_VALID=1.
  - Takes effect immediately, including mid-flush or in FAULT.
- First increment: the first rising edge after rst_n deasserts, if STALL=0.
- Jump accepted at edge N:
  - Cycle N+1: PC=target, JMP_ACK=1, FLUSH=1, PC_VALID=0.
  - Cycles N+1..N+FLUSH_CYCLES: FLUSH=1.
  - Cycle N+FLUSH_CYCLES+1: PC_VALID=1 with PC=target.
  - First increment at the following edge, if STALL=0.
- Requester may drop JMP_REQ in the JMP_ACK cycle. JMP_REQ still high after the ack is ignored during FLUSH. If it is still high on return to RUN, it is a new request.
- Simultaneous STALL=1 and JMP_REQ=1 in RUN: stall wins; no ack.
- Misaligned target at edge N: MISALIGN=1 and PC_VALID=0 from cycle N+1.
- Combinational paths: none from inputs to outputs.

## Test plan
- Reset/step: RESET_PC=32'h100, STALL=0 for 3 cycles -> PC 100,104,108,10C; PC_VALID=1; FLUSH=0.
- Jump: PC=32'h200, JMP_TARGET=32'h1000, JMP_REQ held high until ack:
  - JMP_ACK pulses exactly once; RET_ADDR=32'h204.
  - FLUSH=1 and PC_VALID=0 for 2 cycles.
  - Then PC 1000, 1004 with PC_VALID=1.
- Stall vs jump: STALL=1 with JMP_REQ=1 for 3 cycles -> PC held, no ack. STALL drops -> ack the next cycle.
- Misaligned: JMP_TARGET=32'h1002 -> MISALIGN=1, PC_VALID=0, PC frozen. Later aligned requests get no ack. rst_n=0 clears the fault.
- Wrap: PC=32'hFFFF_FFF8 -> PC FFFF_FFFC then 0000_0000, no fault.
- Reset mid-flush: rst_n=0 in the 1st flush cycle -> immediate PC=RESET_PC, FLUSH=0, JMP_ACK=0, PC_VALID=1.

Source files
------------

// File: rtl/pc_sequencer.sv
// pc_sequencer
// Holds the fetch PC and advances it by PC_STEP on every unstalled RUN cycle.
// A jump request from the jump-target mini ALU is accepted through a
// JMP_REQ/JMP_ACK handshake. An accepted jump loads the target, captures the
// link address and then holds a fixed-length pipeline flush. A misaligned
// target puts the block into a sticky fault state that only reset clears.
//
// Ports:
//   clk         in   rising-edge clock
//   rst_n       in   asynchronous active-low reset
//   STALL       in   holds the PC in RUN; has no effect on an active flush
//   JMP_REQ     in   jump request, held high by the requester until JMP_ACK
//   JMP_TARGET  in   32-bit jump target from the mini ALU
//   PC          out  current fetch address (registered)
//   PC_VALID    out  PC is a valid fetch address (state is RUN)
//   JMP_ACK     out  one-cycle pulse when a jump is accepted
//   RET_ADDR    out  old PC + PC_STEP, captured when a jump is accepted
//   FLUSH       out  high for the whole flush window
//   MISALIGN    out  sticky misaligned-target fault
//
// State   | meaning
// --------+--------------------------------------------------------------
// RUN     | PC steps or holds on STALL; jump requests are evaluated
// FLUSH   | PC held for FLUSH_CYCLES cycles after a taken jump
// FAULT   | misaligned target seen; everything frozen until reset

module pc_sequencer #(
    parameter logic [31:0] RESET_PC     = 32'h0000_0000,
    parameter logic [31:0] PC_STEP      = 32'd4,
    // Legal range 1..15; the flush counter is 4 bits wide.
    parameter int unsigned FLUSH_CYCLES = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        STALL,
    input  logic        JMP_REQ,
    input  logic [31:0] JMP_TARGET,
    output logic [31:0] PC,
    output logic        PC_VALID,
    output logic        JMP_ACK,
    output logic [31:0] RET_ADDR,
    output logic        FLUSH,
    output logic        MISALIGN
);

    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_FLUSH = 2'd1,
        ST_FAULT = 2'd2
    } state_t;

    // The counter is loaded with FLUSH_CYCLES-1 and the window ends on the
    // cycle it reads zero, which gives exactly FLUSH_CYCLES flush cycles.
    localparam logic [3:0] FLUSH_INIT = 4'(FLUSH_CYCLES - 1);

    state_t      state_q,    state_d;
    logic [31:0] pc_q,       pc_d;
    logic [31:0] ret_addr_q, ret_addr_d;
    logic        jmp_ack_q,  jmp_ack_d;
    logic        misalign_q, misalign_d;
    logic [3:0]  cnt_q,      cnt_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_RUN;
            pc_q       <= RESET_PC;
            ret_addr_q <= 32'h0000_0000;
            jmp_ack_q  <= 1'b0;
            misalign_q <= 1'b0;
            cnt_q      <= 4'd0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            ret_addr_q <= ret_addr_d;
            jmp_ack_q  <= jmp_ack_d;
            misalign_q <= misalign_d;
            cnt_q      <= cnt_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        ret_addr_d = ret_addr_q;
        jmp_ack_d  = 1'b0;
        misalign_d = misalign_q;
        cnt_d      = cnt_q;

        case (state_q)
            ST_RUN: begin
                // STALL takes priority: a pending request simply waits.
                if (!STALL) begin
                    if (JMP_REQ) begin
                        if (JMP_TARGET[1:0] == 2'b00) begin
                            pc_d       = JMP_TARGET;
                            ret_addr_d = pc_q + PC_STEP;
                            jmp_ack_d  = 1'b1;
                            cnt_d      = FLUSH_INIT;
                            state_d    = ST_FLUSH;
                        end else begin
                            misalign_d = 1'b1;
                            state_d    = ST_FAULT;
                        end
                    end else begin
                        pc_d = pc_q + PC_STEP;
                    end
                end
            end
            ST_FLUSH: begin
                if (cnt_q == 4'd0) begin
                    state_d = ST_RUN;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            ST_FAULT: begin
            end
            default: begin
                state_d = ST_RUN;
            end
        endcase
    end

    assign PC       = pc_q;
    assign RET_ADDR = ret_addr_q;
    assign JMP_ACK  = jmp_ack_q;
    assign MISALIGN = misalign_q;
    assign PC_VALID = (state_q == ST_RUN);
    assign FLUSH    = (state_q == ST_FLUSH);

endmodule

// File: tb/tb_pc_sequencer.sv
// Self-checking bench for pc_sequencer. The driver applies directed vectors
// and pushes the hand-computed expected outputs into a queue; the monitor
// pops one entry per sample point and compares it against the DUT outputs.
module tb_pc_sequencer;

    logic        clk;
    logic        rst_n;
    logic        stall;
    logic        jmp_req;
    logic [31:0] jmp_target;
    logic [31:0] pc;
    logic        pc_valid;
    logic        jmp_ack;
    logic [31:0] ret_addr;
    logic        flush;
    logic        misalign;

    int checks = 0;
    int errors = 0;

    typedef struct {
        string       name;
        logic [31:0] pc;
        logic        valid;
        logic        flush;
        logic        ack;
        logic        mis;
        logic [31:0] ret;
    } exp_t;

    exp_t exp_q[$];
    event chk_ev;

    pc_sequencer #(
        .RESET_PC    (32'h0000_0100),
        .PC_STEP     (32'd4),
        .FLUSH_CYCLES(2)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .STALL     (stall),
        .JMP_REQ   (jmp_req),
        .JMP_TARGET(jmp_target),
        .PC        (pc),
        .PC_VALID  (pc_valid),
        .JMP_ACK   (jmp_ack),
        .RET_ADDR  (ret_addr),
        .FLUSH     (flush),
        .MISALIGN  (misalign)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Monitor: samples on the falling edge (or on demand for async reset
    // checks) and compares against the oldest expected entry.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk or chk_ev);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                checks++;
                if (pc !== e.pc || pc_valid !== e.valid || flush !== e.flush ||
                    jmp_ack !== e.ack || misalign !== e.mis || ret_addr !== e.ret) begin
                    errors++;
                    $display("FAIL %s: got pc=%h valid=%b flush=%b ack=%b mis=%b ret=%h, want pc=%h valid=%b flush=%b ack=%b mis=%b ret=%h",
                             e.name, pc, pc_valid, flush, jmp_ack, misalign, ret_addr,
                             e.pc, e.valid, e.flush, e.ack, e.mis, e.ret);
                end
            end
        end
    end

    task automatic push(input string nm, input logic [31:0] epc, input logic v,
                        input logic f, input logic a, input logic m,
                        input logic [31:0] ret);
        exp_t e;
        e.name  = nm;
        e.pc    = epc;
        e.valid = v;
        e.flush = f;
        e.ack   = a;
        e.mis   = m;
        e.ret   = ret;
        exp_q.push_back(e);
    endtask

    // Apply inputs, take one rising edge, record the expected post-edge state.
    task automatic step(input string nm, input logic s, input logic r,
                        input logic [31:0] tgt, input logic [31:0] epc,
                        input logic v, input logic f, input logic a,
                        input logic m, input logic [31:0] ret);
        stall      = s;
        jmp_req    = r;
        jmp_target = tgt;
        @(posedge clk);
        #1;
        push(nm, epc, v, f, a, m, ret);
    endtask

    // Assert reset away from the clock edge, check it took effect before
    // the next rising edge, hold it across one edge, then release.
    task automatic async_reset_check(input string nm);
        @(negedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        push(nm, 32'h0000_0100, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
        ->chk_ev;
        stall      = 1'b0;
        jmp_req    = 1'b0;
        jmp_target = 32'h0;
        @(posedge clk);
        @(negedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    initial begin
        rst_n      = 1'b0;
        stall      = 1'b0;
        jmp_req    = 1'b0;
        jmp_target = 32'h0;

        async_reset_check("reset");

        // Sequential stepping from RESET_PC
        step("step1", 0, 0, 32'h0, 32'h104, 1, 0, 0, 0, 32'h0);
        step("step2", 0, 0, 32'h0, 32'h108, 1, 0, 0, 0, 32'h0);
        step("step3", 0, 0, 32'h0, 32'h10C, 1, 0, 0, 0, 32'h0);

        // Move to PC=0x200 via a jump to 0x1F8
        step("j1f8_ack",   0, 1, 32'h1F8, 32'h1F8, 0, 1, 1, 0, 32'h110);
        step("j1f8_fl2",   0, 0, 32'h0,   32'h1F8, 0, 1, 0, 0, 32'h110);
        step("j1f8_run",   0, 0, 32'h0,   32'h1F8, 1, 0, 0, 0, 32'h110);
        step("step_1fc",   0, 0, 32'h0,   32'h1FC, 1, 0, 0, 0, 32'h110);
        step("step_200",   0, 0, 32'h0,   32'h200, 1, 0, 0, 0, 32'h110);

        // Jump from 0x200 to 0x1000; REQ held through the ack cycle
        step("j1000_ack",  0, 1, 32'h1000, 32'h1000, 0, 1, 1, 0, 32'h204);
        step("j1000_fl2",  0, 1, 32'h1000, 32'h1000, 0, 1, 0, 0, 32'h204);
        step("j1000_run",  0, 0, 32'h0,    32'h1000, 1, 0, 0, 0, 32'h204);
        step("step_1004",  0, 0, 32'h0,    32'h1004, 1, 0, 0, 0, 32'h204);

        // Stall beats a jump request; request is honoured once STALL drops
        for (int i = 0; i < 3; i++)
            step("stall_hold", 1, 1, 32'h2000, 32'h1004, 1, 0, 0, 0, 32'h204);
        step("j2000_ack",  0, 1, 32'h2000, 32'h2000, 0, 1, 1, 0, 32'h1008);
        // STALL during flush does not extend it
        step("j2000_fl2",  1, 0, 32'h0,    32'h2000, 0, 1, 0, 0, 32'h1008);
        step("j2000_run",  1, 0, 32'h0,    32'h2000, 1, 0, 0, 0, 32'h1008);
        step("stall_run",  1, 0, 32'h0,    32'h2000, 1, 0, 0, 0, 32'h1008);
        step("step_2004",  0, 0, 32'h0,    32'h2004, 1, 0, 0, 0, 32'h1008);

        // REQ held across the whole flush becomes a new request in RUN
        step("jf8_ack",    0, 1, 32'hFFFF_FFF8, 32'hFFFF_FFF8, 0, 1, 1, 0, 32'h2008);
        step("jf8_fl2",    0, 1, 32'hFFFF_FFF8, 32'hFFFF_FFF8, 0, 1, 0, 0, 32'h2008);
        step("jf8_run",    0, 1, 32'hFFFF_FFF8, 32'hFFFF_FFF8, 1, 0, 0, 0, 32'h2008);
        step("jf8_reack",  0, 1, 32'hFFFF_FFF8, 32'hFFFF_FFF8, 0, 1, 1, 0, 32'hFFFF_FFFC);
        step("jf8_refl2",  0, 0, 32'h0,         32'hFFFF_FFF8, 0, 1, 0, 0, 32'hFFFF_FFFC);
        step("jf8_rerun",  0, 0, 32'h0,         32'hFFFF_FFF8, 1, 0, 0, 0, 32'hFFFF_FFFC);

        // Wrap-around
        step("wrap_fffc",  0, 0, 32'h0, 32'hFFFF_FFFC, 1, 0, 0, 0, 32'hFFFF_FFFC);
        step("wrap_0",     0, 0, 32'h0, 32'h0000_0000, 1, 0, 0, 0, 32'hFFFF_FFFC);
        step("wrap_4",     0, 0, 32'h0, 32'h0000_0004, 1, 0, 0, 0, 32'hFFFF_FFFC);

        // Misaligned target traps; later aligned requests are ignored
        step("misalign",   0, 1, 32'h1002, 32'h4, 0, 0, 0, 1, 32'hFFFF_FFFC);
        step("fault_hold", 0, 1, 32'h3000, 32'h4, 0, 0, 0, 1, 32'hFFFF_FFFC);
        step("fault_hold", 1, 0, 32'h0,    32'h4, 0, 0, 0, 1, 32'hFFFF_FFFC);
        step("fault_hold", 0, 1, 32'h3000, 32'h4, 0, 0, 0, 1, 32'hFFFF_FFFC);

        async_reset_check("fault_reset");

        // Reset in the first flush cycle
        step("j40_ack",    0, 1, 32'h40, 32'h40, 0, 1, 1, 0, 32'h104);
        async_reset_check("flush_reset");
        step("post_rst",   0, 0, 32'h0, 32'h104, 1, 0, 0, 0, 32'h0);

        // Let the monitor drain, bounded
        for (int i = 0; i < 20 && exp_q.size() > 0; i++)
            @(negedge clk);
        #1;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain: got %0d pending entries, want 0", exp_q.size());
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
